// File: rtl/kernel_d_ostream_collect.sv
// Output-stream collector for kernel_D: buffers the kd_vout stream in a show-ahead FIFO,
// counts one frame of NITEMS items and reports busy/done to the host controller.
module kernel_d_ostream_collect #(
    parameter int unsigned STREAMW = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NITEMS  = 1024,
    localparam int unsigned CNTW   = $clog2(NITEMS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               ivalid_i,
    output logic               iready_o,
    input  logic [STREAMW-1:0] din_i,
    output logic               ovalid_o,
    input  logic               oready_i,
    output logic [STREAMW-1:0] dout_o,
    output logic [CNTW-1:0]    count_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNTW-1:0] NItems = CNTW'(NITEMS);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]    in_cnt_q, in_cnt_d;
    logic [CNTW-1:0]    out_cnt_q, out_cnt_d;
    logic [STREAMW-1:0] mem_q [DEPTH];

    logic empty, full, wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en = ivalid_i && iready_o;
    assign rd_en = ovalid_o && oready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (wr_en && (in_cnt_q + CNTW'(1) == NItems)) state_d = StDrain;
            StDrain: if (out_cnt_q == NItems) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; iready depends only on registered state so there is no ready-through path
    always_comb begin
        iready_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        unique case (state_q)
            StRun: begin
                iready_o = !full && (in_cnt_q < NItems);
                busy_o   = 1'b1;
            end
            StDrain: busy_o = 1'b1;
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            in_cnt_d = in_cnt_q + CNTW'(1);
        end
        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            out_cnt_d = out_cnt_q + CNTW'(1);
        end
        if (state_q == StIdle && start_i) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers alone
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    assign ovalid_o = !empty;
    assign dout_o   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign count_o  = out_cnt_q;

endmodule

// File: tb/tb_kernel_d_ostream_collect.sv
// Scoreboard bench for kernel_d_ostream_collect: instance A (DEPTH 8, NITEMS 16) for the
// directed frames, instance B (DEPTH 4, NITEMS 20) for pointer wrap under random stalls.
module tb_kernel_d_ostream_collect;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Instance A
    logic        start_a, ivalid_a, iready_a, oready_a, ovalid_a, busy_a, done_a;
    logic [31:0] din_a, dout_a;
    logic [4:0]  count_a;

    kernel_d_ostream_collect #(.STREAMW(32), .DEPTH(8), .NITEMS(16)) u_dut_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start_a),
        .ivalid_i (ivalid_a),
        .iready_o (iready_a),
        .din_i    (din_a),
        .ovalid_o (ovalid_a),
        .oready_i (oready_a),
        .dout_o   (dout_a),
        .count_o  (count_a),
        .busy_o   (busy_a),
        .done_o   (done_a)
    );

    // Instance B
    logic        start_b, ivalid_b, iready_b, oready_b, ovalid_b, busy_b, done_b;
    logic [31:0] din_b, dout_b;
    logic [4:0]  count_b;

    kernel_d_ostream_collect #(.STREAMW(32), .DEPTH(4), .NITEMS(20)) u_dut_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start_b),
        .ivalid_i (ivalid_b),
        .iready_o (iready_b),
        .din_i    (din_b),
        .ovalid_o (ovalid_b),
        .oready_i (oready_b),
        .dout_o   (dout_b),
        .count_o  (count_b),
        .busy_o   (busy_b),
        .done_o   (done_b)
    );

    logic [31:0] sb_a[$];
    logic [31:0] sb_b[$];
    int acc_a = 0, del_a = 0, dones_a = 0;
    int first_acc_a = -1, first_ov_a = -1, first_del_a = -1, last_del_a = -1;
    int acc_b = 0, del_b = 0, dones_b = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ivalid_a && iready_a) begin
                sb_a.push_back(din_a);
                acc_a++;
                if (first_acc_a < 0) first_acc_a = cyc;
            end
            if (ovalid_a && first_ov_a < 0) first_ov_a = cyc;
            if (ovalid_a && oready_a) begin
                if (sb_a.size() == 0) check("a_spurious_out", dout_a, 32'hdead);
                else check("a_dout_order", dout_a, sb_a.pop_front());
                del_a++;
                if (first_del_a < 0) first_del_a = cyc;
                last_del_a = cyc;
            end
            if (done_a) begin
                dones_a++;
                check("a_count_at_done", 32'(count_a), 32'd16);
                check("a_iready_in_done", 32'(iready_a), 32'd0);
                check("a_busy_in_done", 32'(busy_a), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ivalid_b && iready_b) begin
                sb_b.push_back(din_b);
                acc_b++;
            end
            if (ovalid_b && oready_b) begin
                if (sb_b.size() == 0) check("b_spurious_out", dout_b, 32'hdead);
                else check("b_dout_order", dout_b, sb_b.pop_front());
                del_b++;
            end
            if (done_b) begin
                dones_b++;
                check("b_count_at_done", 32'(count_b), 32'd20);
            end
        end
    end

    task automatic start_frame_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        acc_a = 0;
        del_a = 0;
    endtask

    task automatic produce_a(input int base, input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            bit ok;
            ok = 1'b0;
            din_a    = 32'(base + i);
            ivalid_a = 1'b1;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(negedge clk);
                ok = iready_a;
            end
            if (!ok) begin
                check("a_accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        if (!hold) ivalid_a = 1'b0;
    endtask

    task automatic wait_done_a();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            seen = done_a;
        end
        if (!seen) check("a_done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_iready"}, 32'(iready_a), 32'd0);
        check({tag, "_ovalid"}, 32'(ovalid_a), 32'd0);
        check({tag, "_dout"}, dout_a, 32'd0);
        check({tag, "_count"}, 32'(count_a), 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start_a = 1'b1; ivalid_a = 1'b1; din_a = 32'h55; oready_a = 1'b0;
        start_b = 1'b0; ivalid_b = 1'b0; din_b = '0;    oready_b = 1'b0;

        // Reset with start and ivalid asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero_a("rst");
        @(posedge clk); #1;
        start_a = 1'b0; ivalid_a = 1'b0; rst_n = 1'b1;
        start_frame_a();
        @(negedge clk);
        check("busy_after_start", 32'(busy_a), 32'd1);
        check("count_after_start", 32'(count_a), 32'd0);
        @(posedge clk); #1;

        // Full-rate streaming
        oready_a = 1'b1;
        first_acc_a = -1; first_ov_a = -1; first_del_a = -1; last_del_a = -1;
        produce_a(0, 16, 1'b0);
        wait_done_a();
        check("stream_dones", 32'(dones_a), 32'd1);
        check("stream_latency", 32'(first_ov_a), 32'(first_acc_a + 1));
        check("stream_throughput", 32'(last_del_a - first_del_a), 32'd15);
        check("stream_accepted", 32'(acc_a), 32'd16);
        check("stream_delivered", 32'(del_a), 32'd16);
        check("stream_sb_empty", 32'(sb_a.size()), 32'd0);

        // Backpressure fill, then frame-boundary gating with ivalid held high
        start_frame_a();
        @(negedge clk);
        check("frame2_count_restart", 32'(count_a), 32'd0);
        @(posedge clk); #1;
        oready_a = 1'b0;
        fork
            produce_a(100, 16, 1'b1);
            begin
                repeat (20) @(negedge clk);
                check("fill_accepted", 32'(acc_a), 32'd8);
                check("fill_sb_size", 32'(sb_a.size()), 32'd8);
                check("fill_iready", 32'(iready_a), 32'd0);
                check("fill_ovalid", 32'(ovalid_a), 32'd1);
                check("fill_dout_hold", dout_a, 32'd100);
                @(posedge clk); #1;
                oready_a = 1'b1;
            end
        join
        wait_done_a();
        repeat (3) @(posedge clk);
        #1;
        check("gate_accepted", 32'(acc_a), 32'd16);
        check("gate_delivered", 32'(del_a), 32'd16);
        check("gate_dones", 32'(dones_a), 32'd2);
        check("gate_sb_empty", 32'(sb_a.size()), 32'd0);
        check("idle_iready", 32'(iready_a), 32'd0);
        ivalid_a = 1'b0;

        // Abort mid-frame with asynchronous reset
        start_frame_a();
        oready_a = 1'b0;
        produce_a(200, 5, 1'b0);
        check("abort_pre_accepted", 32'(acc_a), 32'd5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero_a("abort");
        sb_a.delete();
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 32'(dones_a), 32'd2);
        rst_n = 1'b1;
        start_frame_a();
        oready_a = 1'b1;
        produce_a(300, 16, 1'b0);
        wait_done_a();
        check("post_abort_dones", 32'(dones_a), 32'd3);
        check("post_abort_delivered", 32'(del_a), 32'd16);
        check("post_abort_sb_empty", 32'(sb_a.size()), 32'd0);

        // Pointer wrap on the shallow instance with random stalls on both sides
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    bit ok;
                    ok = 1'b0;
                    while ($urandom_range(0, 1) == 1) begin
                        ivalid_b = 1'b0;
                        din_b    = 32'hffff_ffff;
                        @(posedge clk); #1;
                    end
                    din_b    = 32'h1000 + 32'(i * 7);
                    ivalid_b = 1'b1;
                    for (int k = 0; k < 200 && !ok; k++) begin
                        @(negedge clk);
                        ok = iready_b;
                    end
                    if (!ok) begin
                        check("b_accept_timeout", 32'd0, 32'd1);
                        break;
                    end
                    @(posedge clk); #1;
                end
                ivalid_b = 1'b0;
            end
            begin
                for (int k = 0; k < 2000 && dones_b == 0; k++) begin
                    @(posedge clk); #1;
                    oready_b = 1'($urandom_range(0, 1));
                end
                oready_b = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("b_dones", 32'(dones_b), 32'd1);
        check("b_accepted", 32'(acc_b), 32'd20);
        check("b_delivered", 32'(del_b), 32'd20);
        check("b_sb_empty", 32'(sb_b.size()), 32'd0);
        check("b_busy_idle", 32'(busy_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_d_ostream_collect.md
Name: kernel_d_ostream_collect

Overview:
- Downstream neighbour of the kernel_D top: consumes the kd_vout stream through a valid/ready handshake.
- Buffers the stream in a small FIFO and forwards it to the output sink or memory writer.
- Counts accepted and delivered items for one frame of NITEMS elements.
- Reports busy/done so the host-side controller can sequence frames.

Parameters:
- STREAMW, 32: stream data width in bits.
- DEPTH, 8: FIFO depth in entries; must be a power of 2 and at least 2.
- NITEMS, 1024: items per frame; must be at least 1.
- CNTW, $clog2(NITEMS+1): width of the item counters. Local parameter, not overridable.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: frame start request; sampled only in IDLE.
- ivalid, in, 1: upstream data valid, driven from the kernel_D ovalid.
- iready, out, 1: ready to upstream, driving the kernel_D oready.
- din, in, STREAMW: upstream data, from kd_vout_s0.
- ovalid, out, 1: output data valid.
- oready, in, 1: sink ready.
- dout, out, STREAMW: output data.
- count, out, CNTW: items delivered downstream in the current frame.
- busy, out, 1: high in RUN or DRAIN.
- done, out, 1: one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - Read/write pointers=0; in_cnt=0; out_cnt=0.
  - Outputs iready=0, ovalid=0, dout=0, count=0, busy=0, done=0.
  - FIFO contents are discarded.
  - Reset asserted mid-frame aborts the frame; no done pulse; a new start is required.
- FSM states:
  - IDLE: start=1 moves to RUN next cycle and clears in_cnt and out_cnt. Upstream ivalid is ignored and not consumed; iready=0.
  - RUN: iready = !full && (in_cnt < NITEMS). A write occurs on ivalid && iready, and in_cnt increments. On the cycle the write makes in_cnt equal NITEMS, move to DRAIN.
  - DRAIN: iready=0. When out_cnt reaches NITEMS, move to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE. busy=0.
- start outside IDLE is ignored.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits wide.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Wrap-around is natural modulo 2*DEPTH.
- Output side:
  - ovalid = !empty.
  - dout is the show-ahead value mem[rd_ptr].
  - A read occurs on ovalid && oready; out_cnt increments; count=out_cnt.
  - dout and ovalid hold stable while ovalid && !oready.
- Latency: an item written in cycle t appears on ovalid/dout in cycle t+1 at the earliest. There is no combinational write-through bypass.
- Simultaneous events:
  - Read and write in the same cycle, FIFO neither full nor empty: occupancy unchanged.
  - FIFO full: iready=0, even if a read happens that cycle. There is no ready-through path, so iready depends only on registered state.
  - FIFO empty: no read possible, since ovalid=0.
- Last item: if the final read (out_cnt -> NITEMS) coincides with the final write, the FSM still passes RUN -> DRAIN -> DONE in order. DRAIN completes once out_cnt reaches NITEMS.
- Counters saturate logically at NITEMS. They cannot exceed it because iready gates writes and ovalid gates reads.
- Arithmetic: counters are unsigned CNTW-bit. Comparisons are against NITEMS zero-extended to CNTW bits.

Test Plan:
- Reset behaviour: hold rst=0 with ivalid=1 and start=1 → iready=0, ovalid=0, dout=0, count=0, busy=0, done=0. Release rst, then pulse start → busy=1 on the next cycle.
- Streaming throughput: NITEMS=16, DEPTH=8, ivalid=1 and oready=1 continuously, din=0..15.
  - dout delivers 0..15 in order, one per cycle after the first.
  - First ovalid one cycle after the first accept.
  - done pulses once; count=16 at done.
- Backpressure and fill: oready=0, 10 items offered, DEPTH=8.
  - Exactly 8 accepted; iready=0 afterwards; dout holds item 0.
  - Raise oready → items 0..9 delivered in order, with no loss or duplication.
- Pointer wrap with random stalls: NITEMS=20, DEPTH=4, random ivalid/oready at 50% duty. Output order matches input order across several pointer wraps; done pulses exactly once.
- Frame-boundary gating:
  - After NITEMS accepted, ivalid kept at 1 → iready stays 0 in DRAIN and DONE; no extra items are consumed.
  - A second start after done runs a clean second frame with count restarting from 0.
- Abort: assert rst low after 5 of 16 items → all outputs 0 immediately (asynchronously); no done pulse. A new start plus 16 items completes normally.
